err_event_delay_agg: RTL and testbench

//   Multi-channel successor of the CATERR/RMCA delay glue: NUM_CH active-low error inputs
//   (CATERR, RMCA, MEMHOT, etc.), each feeding its own DLY_CNT-cycle assertion-delay timer.
//   Per channel: mask, latch or qualify mode, and sticky hold. Produces undelayed and delayed

---
 rtl/err_event_delay_agg.sv | 130 +++++++++++++
 tb/tb_err_event_delay_agg.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/err_event_delay_agg.sv
// Multi-channel active-low error delay/aggregation with per-channel mask, sticky hold
// and first-error capture for crash-log attribution.
module err_event_delay_agg #(
  parameter int NUM_CH  = 4,
  parameter int DLY_CNT = 1000,
  parameter int QUALIFY = 0,
  localparam int CNT_W  = $clog2(DLY_CNT + 1),
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic [NUM_CH-1:0]   iErr_n,
  input  logic [NUM_CH-1:0]   iMask,
  input  logic [NUM_CH-1:0]   iSticky,
  input  logic                iClr,
  output logic                oErrAny_n,
  output logic [NUM_CH-1:0]   oErrDly_n,
  output logic                oErrAnyDly_n,
  output logic                oFirstVld,
  output logic [CH_W-1:0]     oFirstCh,
  output logic [2*NUM_CH-1:0] oDbgState
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COUNT    = 2'd1,
    ST_ASSERTED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DLY_CNT - 1);

  state_t            state_q [NUM_CH];
  state_t            state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] active;
  logic [NUM_CH-1:0] dly_d;
  logic              first_hit;
  logic [CH_W-1:0]   first_idx;

  assign active    = ~iErr_n & ~iMask;
  assign oErrAny_n = &(iErr_n | iMask);

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (active[i]) begin
            if (DLY_CNT == 1) begin
              state_d[i] = ST_ASSERTED;
            end else begin
              state_d[i] = ST_COUNT;
              cnt_d[i]   = CNT_W'(1);
            end
          end
        end
        ST_COUNT: begin
          // Mask always aborts; a released input aborts only in qualify mode.
          if (iMask[i] || ((QUALIFY != 0) && !active[i])) begin
            state_d[i] = ST_IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_LAST) begin
            state_d[i] = ST_ASSERTED;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        ST_ASSERTED: begin
          if (!active[i] && !iSticky[i]) state_d[i] = ST_IDLE;
        end
        default: begin
          state_d[i] = ST_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
      if (iClr) begin
        state_d[i] = ST_IDLE;
        cnt_d[i]   = '0;
      end
      dly_d[i] = (state_d[i] != ST_ASSERTED);
    end
  end

  // Descending scan so the lowest newly-asserting index wins.
  always_comb begin
    first_hit = 1'b0;
    first_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if ((state_q[i] != ST_ASSERTED) && (state_d[i] == ST_ASSERTED)) begin
        first_hit = 1'b1;
        first_idx = CH_W'(i);
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_IDLE;
        cnt_q[i]   <= '0;
      end
      oErrDly_n    <= '1;
      oErrAnyDly_n <= 1'b1;
      oFirstVld    <= 1'b0;
      oFirstCh     <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      oErrDly_n    <= dly_d;
      oErrAnyDly_n <= &dly_d;
      if (iClr) begin
        oFirstVld <= 1'b0;
        oFirstCh  <= '0;
      end else if (!oFirstVld && first_hit) begin
        oFirstVld <= 1'b1;
        oFirstCh  <= first_idx;
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_dbg
    assign oDbgState[2*g +: 2] = state_q[g];
  end

endmodule

// File: tb/tb_err_event_delay_agg.sv
// Bench for err_event_delay_agg: latch (u0) and qualify (u1) instances share stimulus,
// DLY_CNT=8; expected output words queue at drive time and are compared after the edge.
module tb_err_event_delay_agg;
  localparam int NUM_CH = 4;
  localparam int DLY    = 8;
  localparam int W      = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, clr;
  logic [3:0] err_n, mask, sticky;
  logic       any0, any1, anydly0, anydly1, vld0, vld1;
  logic [3:0] dly0, dly1;
  logic [1:0] ch0, ch1;
  logic [7:0] dbg0, dbg1;

  err_event_delay_agg #(.NUM_CH(NUM_CH), .DLY_CNT(DLY), .QUALIFY(0)) u0 (
    .iClk(clk), .iRst_n(rst_n), .iErr_n(err_n), .iMask(mask), .iSticky(sticky),
    .iClr(clr), .oErrAny_n(any0), .oErrDly_n(dly0), .oErrAnyDly_n(anydly0),
    .oFirstVld(vld0), .oFirstCh(ch0), .oDbgState(dbg0));

  err_event_delay_agg #(.NUM_CH(NUM_CH), .DLY_CNT(DLY), .QUALIFY(1)) u1 (
    .iClk(clk), .iRst_n(rst_n), .iErr_n(err_n), .iMask(mask), .iSticky(sticky),
    .iClr(clr), .oErrAny_n(any1), .oErrDly_n(dly1), .oErrAnyDly_n(anydly1),
    .oFirstVld(vld1), .oFirstCh(ch1), .oDbgState(dbg1));

  typedef struct {
    int ch; int len; int mask_at; bit stk;
    int on0; int off0; int on1; int off1;
  } scen_t;

  typedef struct {
    logic [3:0] e; logic [3:0] m; logic exp_any;
  } comb_t;

  scen_t scen [11];
  comb_t ctab [9];

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q [$];
  string        tag_q [$];

  // Word layout per instance: {anydly, dly[3:0], vld, ch[1:0]}; ch only meaningful when vld.
  function automatic logic [7:0] mk(input logic [3:0] d, input logic v, input logic [1:0] ch);
    return {&d, d, v, v ? ch : 2'b00};
  endfunction

  function automatic logic win(input int c, input int on, input int off);
    return (on >= 0) && (c >= on) && (c < off);
  endfunction

  task automatic step(input logic [3:0] e, input logic [3:0] m, input logic [3:0] s,
                      input logic c, input logic r, input logic exp_any,
                      input logic [W-1:0] exp, input string tag);
    logic [W-1:0] act, ex;
    string        t;
    err_n = e; mask = m; sticky = s; clr = c; rst_n = r;
    #1;
    n_tests++;
    if (any0 !== exp_any || any1 !== exp_any) begin
      n_fail++;
      $display("FAIL %s any_n got=%b/%b exp=%b", tag, any0, any1, exp_any);
    end
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
    ex  = exp_q.pop_front();
    t   = tag_q.pop_front();
    act = {anydly0, dly0, vld0, ex[10] ? ch0 : 2'b00,
           anydly1, dly1, vld1, ex[2]  ? ch1 : 2'b00};
    n_tests++;
    if (act !== ex) begin
      n_fail++;
      $display("FAIL %s outputs got=%h exp=%h", t, act, ex);
    end
  endtask

  task automatic hand(input logic [3:0] e, input logic [3:0] st, input logic c, input logic r,
                      input logic [3:0] d, input logic v, input logic [1:0] ch, input string tag);
    step(e, 4'h0, st, c, r, &e, {mk(d, v, ch), mk(d, v, ch)}, tag);
  endtask

  task automatic cleanup();
    hand(4'hF, 4'h0, 1'b1, 1'b1, 4'hF, 1'b0, 2'b00, "cleanup");
    n_tests++;
    if (dbg0 !== 8'h00 || dbg1 !== 8'h00) begin
      n_fail++;
      $display("FAIL cleanup_state got=%h/%h exp=00", dbg0, dbg1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout tests=%0d", n_tests);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] e, m, st, d0, d1, d;
    logic       v0, v1, v;

    scen[0]  = '{0, 1, -1, 1'b0, 7, 8, -1, 0};
    scen[1]  = '{1, 5, -1, 1'b0, 7, 8, -1, 0};
    scen[2]  = '{1, 20, -1, 1'b0, 7, 20, 7, 20};
    scen[3]  = '{0, 7, -1, 1'b0, 7, 8, -1, 0};
    scen[4]  = '{0, 8, -1, 1'b0, 7, 8, 7, 8};
    scen[5]  = '{2, 9, -1, 1'b0, 7, 9, 7, 9};
    scen[6]  = '{1, 20, 4, 1'b0, -1, 0, -1, 0};
    scen[7]  = '{3, 30, -1, 1'b1, 7, 999, 7, 999};
    scen[8]  = '{2, 3, 7, 1'b0, -1, 0, -1, 0};
    scen[9]  = '{3, 20, 12, 1'b0, 7, 12, 7, 12};
    scen[10] = '{0, 20, 12, 1'b1, 7, 999, 7, 999};

    ctab[0] = '{4'hF, 4'h0, 1'b1};
    ctab[1] = '{4'hE, 4'h0, 1'b0};
    ctab[2] = '{4'h7, 4'h0, 1'b0};
    ctab[3] = '{4'h0, 4'hF, 1'b1};
    ctab[4] = '{4'h0, 4'h0, 1'b0};
    ctab[5] = '{4'hE, 4'h1, 1'b1};
    ctab[6] = '{4'h5, 4'hA, 1'b1};
    ctab[7] = '{4'h3, 4'h8, 1'b0};
    ctab[8] = '{4'hF, 4'hF, 1'b1};

    // Reset state, then the undelayed aggregate exercised while held in reset.
    step(4'hF, 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, {mk(4'hF, 0, 0), mk(4'hF, 0, 0)}, "reset");
    n_tests++;
    if (ch0 !== 2'b00 || ch1 !== 2'b00 || vld0 !== 1'b0 || vld1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first got=%b%h/%b%h exp=000", vld0, ch0, vld1, ch1);
    end
    foreach (ctab[k])
      step(ctab[k].e, ctab[k].m, 4'h0, 1'b0, 1'b0, ctab[k].exp_any,
           {mk(4'hF, 0, 0), mk(4'hF, 0, 0)}, $sformatf("comb%0d", k));
    for (int k = 0; k < 8; k++) begin
      e = 4'($urandom_range(0, 15));
      m = 4'($urandom_range(0, 15));
      step(e, m, 4'h0, 1'b0, 1'b0, &(e | m), {mk(4'hF, 0, 0), mk(4'hF, 0, 0)},
           $sformatf("comb_rand%0d", k));
    end
    hand(4'hF, 4'h0, 1'b0, 1'b1, 4'hF, 1'b0, 2'b00, "release");

    // Single-channel scenario table, both modes checked every cycle.
    for (int k = 0; k < 11; k++) begin
      for (int c = 0; c < 40; c++) begin
        e = 4'hF; m = 4'h0; st = 4'h0;
        if (c < scen[k].len) e[scen[k].ch] = 1'b0;
        if (scen[k].mask_at >= 0 && c >= scen[k].mask_at) m[scen[k].ch] = 1'b1;
        if (scen[k].stk) st[scen[k].ch] = 1'b1;
        d0 = 4'hF; d0[scen[k].ch] = ~win(c, scen[k].on0, scen[k].off0);
        d1 = 4'hF; d1[scen[k].ch] = ~win(c, scen[k].on1, scen[k].off1);
        v0 = (scen[k].on0 >= 0) && (c >= scen[k].on0);
        v1 = (scen[k].on1 >= 0) && (c >= scen[k].on1);
        step(e, m, st, 1'b0, 1'b1, &(e | m),
             {mk(d0, v0, 2'(scen[k].ch)), mk(d1, v1, 2'(scen[k].ch))},
             $sformatf("scen%0d_c%0d", k, c));
      end
      cleanup();
    end

    // ch2 and ch3 on the same edge: lowest index captured.
    for (int c = 0; c < 15; c++) begin
      e = 4'hF; if (c < 12) e = 4'h3;
      d = 4'hF; d[2] = ~win(c, 7, 12); d[3] = ~win(c, 7, 12);
      hand(e, 4'h0, 1'b0, 1'b1, d, c >= 7, 2'd2, $sformatf("same_edge_c%0d", c));
    end
    cleanup();

    // ch3 first, ch1 later: the later entry must not overwrite the capture.
    for (int c = 0; c < 18; c++) begin
      e = 4'hF;
      if (c < 15) e[3] = 1'b0;
      if (c >= 2 && c < 15) e[1] = 1'b0;
      d = 4'hF; d[3] = ~win(c, 7, 15); d[1] = ~win(c, 9, 15);
      hand(e, 4'h0, 1'b0, 1'b1, d, c >= 7, 2'd3, $sformatf("first_hold_c%0d", c));
    end
    cleanup();

    // Sticky hold released by iClr.
    for (int c = 0; c < 16; c++) begin
      e = 4'hF; if (c < 10) e[0] = 1'b0;
      d = 4'hF; d[0] = ~win(c, 7, 12);
      hand(e, 4'h1, c == 12, 1'b1, d, win(c, 7, 12), 2'd0, $sformatf("sticky_c%0d", c));
    end
    cleanup();

    // Input held low across iClr at the arming edge and while asserted: fresh counts.
    for (int c = 0; c < 24; c++) begin
      d = 4'hF; v = win(c, 8, 12) || win(c, 20, 99); d[0] = ~v;
      hand(4'hE, 4'h1, (c == 0) || (c == 12), 1'b1, d, v, 2'd0, $sformatf("sticky_rearm_c%0d", c));
    end
    cleanup();

    // iClr on the edge that would complete the count.
    for (int c = 0; c < 18; c++) begin
      d = 4'hF; d[0] = ~win(c, 15, 99);
      hand(4'hE, 4'h0, c == 7, 1'b1, d, c >= 15, 2'd0, $sformatf("clr_beats_c%0d", c));
    end
    cleanup();

    // Reset mid-count at cnt=5, then a full fresh delay.
    for (int c = 0; c < 16; c++) begin
      d = 4'hF; d[0] = ~win(c, 13, 99);
      hand(4'hE, 4'h0, 1'b0, c != 5, d, c >= 13, 2'd0, $sformatf("rst_mid_c%0d", c));
    end
    cleanup();

    // Reset clears a sticky assertion and the capture.
    for (int c = 0; c < 15; c++) begin
      e = 4'hF; if (c < 10) e[1] = 1'b0;
      d = 4'hF; d[1] = ~win(c, 7, 12);
      hand(e, 4'h2, 1'b0, c != 12, d, win(c, 7, 12), 2'd1, $sformatf("rst_sticky_c%0d", c));
      if (c == 12) begin
        n_tests++;
        if (ch0 !== 2'b00 || ch1 !== 2'b00) begin
          n_fail++;
          $display("FAIL rst_first_ch got=%h/%h exp=0", ch0, ch1);
        end
      end
    end
    cleanup();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
